adat_frame_reader: RTL and testbench

//  Downstream of the ADAT decoder. Watches the committed-frame index and reads each newly committed frame
//  out of the bit-serial circular RAM (addr = {frame, channel[2:0], bit[4:0]}, 1-bit data).

---
 rtl/adat_frame_reader.sv | 172 +++++++++++++++++
 tb/tb_adat_frame_reader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adat_frame_reader.sv
// ADAT frame reader: pulls committed frames out of the bit-serial RAM as 8 x 24-bit samples.
// Optional ADAT_USER_BITS_EN: user bits ride in sample_o[3:0] of every word of a frame.
module adat_frame_reader #(
  parameter int CIRC_BUF_BITS = 3
) (
  input  logic                       clk_x4_i,
  input  logic                       reset_ni,
  input  logic                       has_sync_i,
  input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
  input  logic [3:0]                 user_bits_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
  input  logic                       ram_read_data_i,
  output logic [31:0]                sample_o,
  output logic [2:0]                 channel_o,
  output logic                       sample_valid_o,
  input  logic                       sample_ready_i,
  output logic                       overrun_o,
  output logic                       busy_o
);

  localparam int IW = CIRC_BUF_BITS;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic [IW-1:0] pend_idx_q, pend_idx_d;
  logic [IW-1:0] cur_idx_q, cur_idx_d;
  logic [2:0]    ch_q, ch_d;
  logic [4:0]    bit_q, bit_d;
  logic          drain_q, drain_d;
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic [23:0]   sr_q, sr_d;
  logic [IW+7:0] addr_q, addr_d;
  logic [31:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic [3:0]    user_q, user_d;
  logic [7:0]    low_byte;
  logic          new_frame;
  logic          take;

`ifdef ADAT_USER_BITS_EN
  assign low_byte = {4'h0, user_q};
`else
  logic unused_user;
  assign unused_user = ^user_q;
  assign low_byte = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    pend_idx_d = pend_idx_q;
    cur_idx_d  = cur_idx_q;
    ch_d       = ch_q;
    bit_d      = bit_q;
    drain_d    = drain_q;
    addr_d     = addr_q;
    sample_d   = sample_q;
    valid_d    = valid_q;
    user_d     = user_q;
    idx_d      = last_good_frame_idx_i;
    new_frame  = has_sync_i && (last_good_frame_idx_i != idx_q);
    take       = (state_q == S_IDLE) && pending_q && has_sync_i;
    overrun_d  = new_frame && pending_q && !take;
    v1_d       = (state_q == S_FETCH);
    v2_d       = v1_q;
    sr_d       = v2_q ? {sr_q[22:0], ram_read_data_i} : sr_q;
    // A frame committed in the same cycle as the take stays pending.
    if (take) pending_d = 1'b0;
    if (new_frame) begin
      pending_d  = 1'b1;
      pend_idx_d = last_good_frame_idx_i;
    end
    if (!has_sync_i) pending_d = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (take) begin
          cur_idx_d = pend_idx_q;
          user_d    = user_bits_i;
          ch_d      = 3'd0;
          bit_d     = 5'd0;
          addr_d    = {pend_idx_q, 3'd0, 5'd0};
          state_d   = S_FETCH;
        end
      end
      (state_q == S_FETCH): begin
        if (bit_q == 5'd23) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          bit_d  = bit_q + 5'd1;
          addr_d = {cur_idx_q, ch_q, bit_q + 5'd1};
        end
      end
      (state_q == S_DRAIN): begin
        if (drain_q) begin
          sample_d = {sr_d, low_byte};
          valid_d  = 1'b1;
          state_d  = S_PRESENT;
        end else begin
          drain_d = 1'b1;
        end
      end
      (state_q == S_PRESENT): begin
        if (sample_ready_i) begin
          valid_d = 1'b0;
          if (ch_q == 3'd7) begin
            state_d = S_IDLE;
          end else begin
            ch_d    = ch_q + 3'd1;
            bit_d   = 5'd0;
            addr_d  = {cur_idx_q, ch_q + 3'd1, 5'd0};
            state_d = S_FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_x4_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      pend_idx_q <= '0;
      cur_idx_q  <= '0;
      ch_q       <= 3'd0;
      bit_q      <= 5'd0;
      drain_q    <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      sr_q       <= 24'd0;
      addr_q     <= '0;
      sample_q   <= 32'd0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      user_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      pend_idx_q <= pend_idx_d;
      cur_idx_q  <= cur_idx_d;
      ch_q       <= ch_d;
      bit_q      <= bit_d;
      drain_q    <= drain_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      sr_q       <= sr_d;
      addr_q     <= addr_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      user_q     <= user_d;
    end
  end

  assign ram_read_addr_o = addr_q;
  assign sample_o        = sample_q;
  assign channel_o       = ch_q;
  assign sample_valid_o  = valid_q;
  assign overrun_o       = overrun_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_adat_frame_reader.sv
// Bench for adat_frame_reader: frame-level reference model plus directed
// latency/stall/overrun/reset scenarios and a randomized soak.
module tb_adat_frame_reader;

`ifdef ADAT_USER_BITS_EN
  localparam logic [7:0] LOWMASK = 8'h0F;
`else
  localparam logic [7:0] LOWMASK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync = 1'b0;
  logic [2:0]  last = 3'd0;
  logic [3:0]  user = 4'hB;
  logic [10:0] ram_addr;
  logic        p1 = 1'b0;
  logic        p2 = 1'b0;
  logic [31:0] sample;
  logic [2:0]  channel;
  logic        valid;
  logic        ready = 1'b1;
  logic        overrun;
  logic        busy;

  logic [23:0] mem [8][8];
  logic [34:0] acc_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_ovr = 0;

  // frame-level model state
  int m_idx = 0, m_pend = 0, m_pidx = 0, m_busy = 0, m_valid = 0;
  int m_ch = 0, m_cnt = 0, m_cur = 0, m_ovr = 0;
  logic [3:0] m_user = 4'h0;

  always #5 clk = ~clk;

  adat_frame_reader #(.CIRC_BUF_BITS(3)) dut (
    .clk_x4_i              (clk),
    .reset_ni              (rst_n),
    .has_sync_i            (sync),
    .last_good_frame_idx_i (last),
    .user_bits_i           (user),
    .ram_read_addr_o       (ram_addr),
    .ram_read_data_i       (p2),
    .sample_o              (sample),
    .channel_o             (channel),
    .sample_valid_o        (valid),
    .sample_ready_i        (ready),
    .overrun_o             (overrun),
    .busy_o                (busy)
  );

  function automatic logic [7:0] lowb(logic [3:0] u);
    return {4'h0, u} & LOWMASK;
  endfunction

  function automatic logic ram_bit(logic [10:0] a);
    int b;
    b = int'(a[4:0]);
    if (b > 23) return 1'b0;
    return mem[a[10:8]][a[7:5]][23 - b];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // RAM with 2-cycle read latency
  initial forever begin
    @(posedge clk);
    p1 <= ram_bit(ram_addr);
    p2 <= p1;
  end

  // reference model: one update per clock edge, async reset
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_idx = 0; m_pend = 0; m_pidx = 0; m_busy = 0; m_valid = 0;
      m_ch = 0; m_cnt = 0; m_cur = 0; m_ovr = 0; m_user = 4'h0;
    end else begin
      int ob, op, nf, tk;
      ob = m_busy;
      op = m_pend;
      nf = (sync && int'(last) != m_idx) ? 1 : 0;
      tk = (!ob && op && sync) ? 1 : 0;
      if (m_busy) begin
        if (m_valid) begin
          if (ready) begin
            m_valid = 0;
            if (m_ch == 7) m_busy = 0;
            else begin
              m_ch++;
              m_cnt = 26;
            end
          end
        end else if (m_cnt == 1) m_valid = 1;
        else m_cnt--;
      end
      if (tk) begin
        m_busy = 1; m_cur = m_pidx; m_user = user;
        m_ch = 0; m_cnt = 26; m_valid = 0; m_pend = 0;
      end
      m_ovr = (nf && op && !tk) ? 1 : 0;
      if (nf) begin
        m_pend = 1;
        m_pidx = int'(last);
      end
      if (!sync) m_pend = 0;
      m_idx = int'(last);
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("valid", valid, m_valid);
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_ovr);
      if (m_valid) begin
        chk("sample", sample, {mem[m_cur][m_ch], lowb(m_user)});
        chk("channel", channel, m_ch);
      end
    end
  end

  // accepted-word log and overrun counter
  initial forever begin
    @(posedge clk);
    if (rst_n && valid && ready) acc_q.push_back({channel, sample});
    if (rst_n && overrun) n_ovr++;
  end

  task automatic wait_valid_ch(input int ch, input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (valid && int'(channel) == ch) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic wait_words(input int cnt, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (acc_q.size() >= cnt) return;
      @(negedge clk);
    end
    chk("word_timeout", acc_q.size(), cnt);
  endtask

  initial begin
    int n, qs, o0;
    logic [31:0] snap;
    logic [2:0] nx;
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 8; c++) mem[s][c] = 24'($urandom);
    for (int c = 0; c < 8; c++) begin
      mem[1][c] = 24'(32'h100000 * c + c);
      mem[2][c] = 24'(32'h100000 * c + c);
    end
    mem[1][0] = 24'hA5C3F0;
    mem[5][0] = ~mem[6][0];

    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_sample", sample, 0);
    chk("rst_channel", channel, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sync = 1'b1;
    repeat (2) @(negedge clk);

    // first frame: latency and first word
    last = 3'd1;
    wait_valid_ch(0, 40, n);
    chk("t1_latency", n, 28);
    chk("t1_sample", sample, {24'hA5C3F0, lowb(4'hB)});
    chk("t1_channel", channel, 0);
    wait_words(8, 400);
    repeat (3) @(negedge clk);
    chk("t1_words", acc_q.size(), 8);
    chk("t1_busy_low", busy, 0);

    // full frame in channel order
    acc_q.delete();
    last = 3'd2;
    wait_words(8, 400);
    repeat (3) @(negedge clk);
    chk("t2_words", acc_q.size(), 8);
    chk("t2_busy_low", busy, 0);
    for (int i = 0; i < 8 && i < acc_q.size(); i++)
      chk("t2_chan", acc_q[i][34:32], i);
    if (acc_q.size() == 8) begin
      chk("t2_ch3", acc_q[3][31:0], {24'h300003, lowb(4'hB)});
      chk("t2_ch7", acc_q[7][31:0], {24'h700007, lowb(4'hB)});
    end

    // stall at channel 3
    last = 3'd3;
    wait_valid_ch(3, 300, n);
    chk("t3_reach_ch3", n > 0, 1);
    ready = 1'b0;
    snap = sample;
    repeat (100) @(negedge clk);
    chk("t3_hold_sample", sample, snap);
    chk("t3_hold_valid", valid, 1);
    chk("t3_hold_chan", channel, 3);
    ready = 1'b1;
    wait_valid_ch(4, 40, n);
    chk("t3_next_latency", n, 27);
    repeat (250) @(negedge clk);
    chk("t3_done", busy, 0);

    // overrun: 4 in flight, 5 replaced by 6
    ready = 1'b0;
    last = 3'd4;
    wait_valid_ch(0, 60, n);
    o0 = n_ovr;
    acc_q.delete();
    repeat (5) @(negedge clk);
    last = 3'd5;
    repeat (5) @(negedge clk);
    last = 3'd6;
    repeat (5) @(negedge clk);
    chk("t4_overruns", n_ovr - o0, 1);
    ready = 1'b1;
    wait_words(16, 800);
    repeat (300) @(negedge clk);
    chk("t4_words", acc_q.size(), 16);
    if (acc_q.size() >= 16) begin
      chk("t4_first_of_6", acc_q[8][31:0], {mem[6][0], lowb(4'hB)});
      for (int i = 8; i < 16; i++)
        chk("t4_slot6", acc_q[i], {3'(i - 8), mem[6][i - 8], lowb(4'hB)});
    end

    // async reset in the middle of channel 5 fetch
    last = 3'd7;
    wait_valid_ch(4, 300, n);
    chk("t5_reach_ch4", n > 0, 1);
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sync = 1'b0;
    #1;
    chk("t5_valid_async", valid, 0);
    chk("t5_busy_async", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sync = 1'b1;
    qs = acc_q.size();
    repeat (60) @(negedge clk);
    chk("t5_quiet", acc_q.size(), qs);
    chk("t5_idle", busy, 0);
    last = 3'd0;
    wait_words(qs + 8, 400);

    // randomized soak
    for (int k = 0; k < 25; k++) begin
      nx = 3'($urandom_range(0, 7));
      if (nx == last) nx = nx + 3'd1;
      user = 4'($urandom);
      if (k == 10) begin
        sync = 1'b0;
        repeat (20) @(negedge clk);
        sync = 1'b1;
      end
      last = nx;
      repeat ($urandom_range(150, 450)) begin
        @(negedge clk);
        ready = ($urandom_range(0, 3) != 0);
      end
    end
    ready = 1'b1;
    repeat (400) @(negedge clk);
    chk("end_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
